// File: rtl/fetch_decode_controller_pkg.sv
// Shared types and constants for the fetch/decode sequencer: state encoding,
// opcode constants, PC step and instruction field bit positions.
package fetch_decode_controller_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_HALT
    } state_t;

    localparam logic [5:0]        RTYPE_OPCODE        = 6'b000000;
    localparam logic [5:0]        DEFAULT_HALT_OPCODE = 6'b111111;
    localparam logic [DATA_W-1:0] PC_STEP             = 32'd4;

    // MIPS-style field layout of the 32-bit instruction word
    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;

endpackage

// File: rtl/fetch_decode_controller_if.sv
// Bundle of the instruction-memory fetch bus and the decoded-instruction
// handshake; master is the controller, slave is memory/downstream.
interface fetch_decode_controller_if;
    import fetch_decode_controller_pkg::*;

    logic              start;
    logic              imem_req;
    logic [DATA_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic              dec_valid;
    logic              dec_ready;
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [5:0]        funct;
    logic              is_rtype;
    logic [DATA_W-1:0] pc;
    logic              busy;
    logic              halted;

    modport master (
        input  start, imem_ack, imem_rdata, dec_ready,
        output imem_req, imem_addr, dec_valid, opcode, rs, rt, rd, funct,
               is_rtype, pc, busy, halted
    );

    modport slave (
        output start, imem_ack, imem_rdata, dec_ready,
        input  imem_req, imem_addr, dec_valid, opcode, rs, rt, rd, funct,
               is_rtype, pc, busy, halted
    );

endinterface

// File: rtl/fetch_decode_controller_field_decode.sv
// Combinational field extraction: R-type instructions expose register and
// funct fields, every other opcode reports them as zero.
module instr_field_decode
    import fetch_decode_controller_pkg::*;
(
    input  logic [DATA_W-1:0] instr,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [5:0]        funct,
    output logic              is_rtype
);

    // shamt has no consumer in this sequencer
    logic unused_shamt;
    assign unused_shamt = ^instr[SHAMT_HI:SHAMT_LO];

    always_comb begin
        opcode   = instr[OPC_HI:OPC_LO];
        is_rtype = 1'b0;
        rs       = '0;
        rt       = '0;
        rd       = '0;
        funct    = '0;
        if (instr[OPC_HI:OPC_LO] == RTYPE_OPCODE) begin
            is_rtype = 1'b1;
            rs       = instr[RS_HI:RS_LO];
            rt       = instr[RT_HI:RT_LO];
            rd       = instr[RD_HI:RD_LO];
            funct    = instr[FUNCT_HI:FUNCT_LO];
        end
    end

endmodule

// File: rtl/fetch_decode_controller.sv
// Instruction fetch/decode sequencer: fetches at pc, decodes for one cycle,
// then holds the decoded fields until downstream accepts them.
module fetch_decode_controller
    import fetch_decode_controller_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]        HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
    input logic                     clk,
    input logic                     rst,
    fetch_decode_controller_if.master bus
);

    state_t            state;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] instr_q;
    logic [5:0]        opcode_q;
    logic [4:0]        rs_q;
    logic [4:0]        rt_q;
    logic [4:0]        rd_q;
    logic [5:0]        funct_q;
    logic              is_rtype_q;
    logic              imem_req_q;
    logic              dec_valid_q;
    logic              busy_q;
    logic              halted_q;

    logic [5:0] d_opcode;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [4:0] d_rd;
    logic [5:0] d_funct;
    logic       d_is_rtype;

    instr_field_decode u_field_decode (
        .instr    (instr_q),
        .opcode   (d_opcode),
        .rs       (d_rs),
        .rt       (d_rt),
        .rd       (d_rd),
        .funct    (d_funct),
        .is_rtype (d_is_rtype)
    );

    // Outputs are registered alongside the state so each one tracks the
    // state it belongs to without decode glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            opcode_q    <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            funct_q     <= '0;
            is_rtype_q  <= 1'b0;
            imem_req_q  <= 1'b0;
            dec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state      <= S_FETCH;
                        imem_req_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        instr_q    <= bus.imem_rdata;
                        imem_req_q <= 1'b0;
                        state      <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    opcode_q   <= d_opcode;
                    rs_q       <= d_rs;
                    rt_q       <= d_rt;
                    rd_q       <= d_rd;
                    funct_q    <= d_funct;
                    is_rtype_q <= d_is_rtype;
                    if (d_opcode == HALT_OPCODE) begin
                        state    <= S_HALT;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        state       <= S_ISSUE;
                        dec_valid_q <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (bus.dec_ready) begin
                        dec_valid_q <= 1'b0;
                        pc_q        <= pc_q + PC_STEP;
                        imem_req_q  <= 1'b1;
                        state       <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state       <= S_IDLE;
                    imem_req_q  <= 1'b0;
                    dec_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    halted_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc_q;
    assign bus.pc        = pc_q;
    assign bus.dec_valid = dec_valid_q;
    assign bus.opcode    = opcode_q;
    assign bus.rs        = rs_q;
    assign bus.rt        = rt_q;
    assign bus.rd        = rd_q;
    assign bus.funct     = funct_q;
    assign bus.is_rtype  = is_rtype_q;
    assign bus.busy      = busy_q;
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_fetch_decode_controller.sv
// Directed plus randomized bench for fetch_decode_controller with a
// word-level reference decoder and expected-pc tracker.
module tb_fetch_decode_controller;
    import fetch_decode_controller_pkg::*;

    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam logic [31:0] RPC2  = 32'hFFFF_FFFC;
    localparam logic [5:0]  HALTO = 6'h3F;

    typedef struct packed {
        logic [5:0] opc;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [5:0] fn;
        logic       rtype;
    } fields_t;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;
    logic [31:0] exp_pc;

    fetch_decode_controller_if bus ();
    fetch_decode_controller_if bus2 ();

    fetch_decode_controller #(.RESET_PC(RPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    fetch_decode_controller #(.RESET_PC(RPC2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Reference decode from the instruction word using plain arithmetic
    function automatic fields_t ref_decode(input logic [31:0] w);
        fields_t f;
        int unsigned u;
        u = w;
        f = '0;
        f.opc = 6'(u / 67108864);
        if (f.opc == 6'd0) begin
            f.rtype = 1'b1;
            f.rs    = 5'((u / 2097152) % 32);
            f.rt    = 5'((u / 65536) % 32);
            f.rd    = 5'((u / 2048) % 32);
            f.fn    = 6'(u % 64);
        end
        return f;
    endfunction

    task automatic check_fields(input string tag, input fields_t f);
        check({tag, "_opcode"}, 32'(bus.opcode), 32'(f.opc));
        check({tag, "_rs"}, 32'(bus.rs), 32'(f.rs));
        check({tag, "_rt"}, 32'(bus.rt), 32'(f.rt));
        check({tag, "_rd"}, 32'(bus.rd), 32'(f.rd));
        check({tag, "_funct"}, 32'(bus.funct), 32'(f.fn));
        check({tag, "_rtype"}, 32'(bus.is_rtype), 32'(f.rtype));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req"}, 32'(bus.imem_req), 32'd0);
        check({tag, "_valid"}, 32'(bus.dec_valid), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_halted"}, 32'(bus.halted), 32'd0);
        check({tag, "_pc"}, bus.pc, RPC);
        check({tag, "_addr"}, bus.imem_addr, RPC);
        check_fields(tag, '0);
    endtask

    // Entered one step after the DUT moved into FETCH; leaves it in FETCH
    // (or HALT for a halt opcode).
    task automatic run_instr(input logic [31:0] w, input int ack_dly, input int rdy_dly);
        fields_t f;
        f = ref_decode(w);
        check("fetch_req", 32'(bus.imem_req), 32'd1);
        check("fetch_addr", bus.imem_addr, exp_pc);
        check("fetch_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < ack_dly; i++) begin
            bus.imem_ack   = 1'b0;
            bus.start      = 1'($urandom);
            bus.dec_ready  = 1'($urandom);
            bus.imem_rdata = $urandom;
            tick();
            check("wait_addr", bus.imem_addr, exp_pc);
            check("wait_req", 32'(bus.imem_req), 32'd1);
            check("wait_valid", 32'(bus.dec_valid), 32'd0);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = w;
        bus.start      = 1'b0;
        tick();
        bus.imem_ack   = 1'($urandom);
        bus.imem_rdata = $urandom;
        bus.dec_ready  = 1'($urandom);
        check("decode_req", 32'(bus.imem_req), 32'd0);
        check("decode_valid", 32'(bus.dec_valid), 32'd0);
        tick();
        bus.dec_ready = 1'b0;
        if (f.opc == HALTO) begin
            bus.imem_ack = 1'b0;
            check("halt_halted", 32'(bus.halted), 32'd1);
            check("halt_busy", 32'(bus.busy), 32'd0);
            check("halt_valid", 32'(bus.dec_valid), 32'd0);
            check("halt_req", 32'(bus.imem_req), 32'd0);
            return;
        end
        check("issue_valid", 32'(bus.dec_valid), 32'd1);
        check("issue_pc", bus.pc, exp_pc);
        check_fields("issue", f);
        for (int i = 0; i < rdy_dly; i++) begin
            bus.imem_ack = 1'($urandom);
            bus.start    = 1'($urandom);
            tick();
            check("hold_valid", 32'(bus.dec_valid), 32'd1);
            check("hold_pc", bus.pc, exp_pc);
            check("hold_req", 32'(bus.imem_req), 32'd0);
            check_fields("hold", f);
        end
        bus.dec_ready = 1'b1;
        bus.imem_ack  = 1'($urandom);
        tick();
        bus.dec_ready = 1'b0;
        bus.imem_ack  = 1'b0;
        bus.start     = 1'b0;
        check("post_valid", 32'(bus.dec_valid), 32'd0);
        exp_pc = exp_pc + 32'd4;
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b1;
        bus.start = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.dec_ready = 1'b0;
        bus2.start = 1'b0; bus2.imem_ack = 1'b0; bus2.imem_rdata = '0; bus2.dec_ready = 1'b0;
        repeat (2) tick();
        // reset wins over simultaneous start/ack/ready
        bus.start = 1'b1; bus.imem_ack = 1'b1; bus.dec_ready = 1'b1;
        tick();
        rst = 1'b0; bus.start = 1'b0;
        check_reset("reset");

        // ack/ready in IDLE do nothing
        tick();
        bus.imem_ack = 1'b0; bus.dec_ready = 1'b0;
        check("idle_req", 32'(bus.imem_req), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_pc = RPC;
        run_instr(32'h012A_4020, 0, 0);
        run_instr(32'h8D09_0004, 0, 5);
        run_instr(32'h8D09_0004, 3, 1);

        for (int n = 0; n < 24; n++) begin
            w = $urandom;
            if (w[31:26] == HALTO) w[31:26] = 6'h23;
            if ($urandom_range(1, 0) == 1) w[31:26] = 6'h00;
            run_instr(w, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
        end

        // reset while a fetch is outstanding, ack arrives after reset
        bus.imem_ack = 1'b0;
        tick();
        check("rstf_req", 32'(bus.imem_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h012A_4020;
        tick();
        bus.imem_ack = 1'b0;
        check_reset("rstf");
        repeat (3) begin
            tick();
            check("rstf_quiet_valid", 32'(bus.dec_valid), 32'd0);
            check("rstf_quiet_req", 32'(bus.imem_req), 32'd0);
        end

        // reset while issuing beats a same-cycle ready
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_2820;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        check("rsti_valid", 32'(bus.dec_valid), 32'd1);
        rst = 1'b1; bus.dec_ready = 1'b1;
        tick();
        rst = 1'b0; bus.dec_ready = 1'b0;
        check_reset("rsti");

        // halt opcode
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_pc = RPC;
        run_instr(32'h012A_4020, 1, 0);
        run_instr(32'hFC00_0000, 1, 0);
        bus.start = 1'b1; bus.imem_ack = 1'b1; bus.dec_ready = 1'b1;
        repeat (3) begin
            tick();
            check("halted_stay", 32'(bus.halted), 32'd1);
            check("halted_busy", 32'(bus.busy), 32'd0);
            check("halted_req", 32'(bus.imem_req), 32'd0);
            check("halted_valid", 32'(bus.dec_valid), 32'd0);
            check("halted_pc", bus.pc, RPC + 32'd4);
        end
        bus.start = 1'b0; bus.imem_ack = 1'b0; bus.dec_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("unhalt");

        // pc wrap on the second instance
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        check("wrap_addr0", bus2.imem_addr, RPC2);
        bus2.imem_ack = 1'b1; bus2.imem_rdata = 32'h012A_4020;
        tick();
        bus2.imem_ack = 1'b0;
        tick();
        check("wrap_valid", 32'(bus2.dec_valid), 32'd1);
        check("wrap_rtype", 32'(bus2.is_rtype), 32'd1);
        bus2.dec_ready = 1'b1;
        tick();
        bus2.dec_ready = 1'b0;
        check("wrap_req", 32'(bus2.imem_req), 32'd1);
        check("wrap_addr1", bus2.imem_addr, RPC2 + 32'd4);
        check("wrap_addr_zero", bus2.imem_addr, 32'h0000_0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
